irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/irq_ctrl.sv
// irq_ctrl: four-source interrupt controller driving a 68000-style active-low IPL.
// Sources are synchronised, latched (edge mode) or tracked (level mode), masked,
// and prioritised. A small FSM sequences request, acknowledge and recovery.
module irq_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  src,
    input  logic        cs,
    input  logic [2:0]  address,
    input  logic [1:0]  wr,
    input  logic [15:0] din,
    output logic [15:0] dout,
    input  logic        iack,
    input  logic [2:0]  iack_level,
    output logic [2:0]  ipl_n
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        ACK     = 2'd2,
        RECOVER = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_next_s;

    logic [3:0]  s1_r;
    logic [3:0]  s2_r;
    logic [3:0]  pending_r;
    logic [3:0]  enable_r;
    logic [3:0]  mode_r;
    logic [11:0] level_r;
    logic        spurious_r;
    logic        in_service_r;
    logic        iack_d_r;
    logic [2:0]  ipl_n_r;

    logic [3:0]  edge_s;
    logic [3:0]  active_s;
    logic [3:0]  hit_s;
    logic [3:0]  ack_cand_s;
    logic [3:0]  ack_clr_s;
    logic [3:0]  w1c_s;
    logic [3:0]  pending_next_s;
    logic [2:0]  req_level_s;
    logic [2:0]  ipl_n_next_s;
    logic        iack_rise_s;
    logic        ack_entry_s;
    logic        spur_set_s;
    logic        wr_lo_s;
    logic        wr_hi_s;

    // Highest 3-bit level among the flagged sources (0 when none are flagged).
    function automatic logic [2:0] max_level(input logic [3:0] act, input logic [11:0] lv);
        logic [2:0] m;
        m = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (act[i] && (lv[3*i +: 3] > m)) begin
                m = lv[3*i +: 3];
            end else begin
                m = m;
            end
        end
        return m;
    endfunction

    // Keep only the lowest set bit of a 4-bit vector.
    function automatic logic [3:0] lowest_one(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    // Source qualification, priority resolution, acknowledge decode and pending update.
    always_comb begin
        edge_s   = s1_r & ~s2_r;
        active_s = 4'd0;
        hit_s    = 4'd0;
        for (int i = 0; i < 4; i++) begin
            active_s[i] = pending_r[i] & enable_r[i] & (level_r[3*i +: 3] != 3'd0);
            hit_s[i]    = active_s[i] & (level_r[3*i +: 3] == iack_level);
        end
        req_level_s = max_level(active_s, level_r);
        iack_rise_s = iack & ~iack_d_r;
        ack_entry_s = (state_r == REQ) && iack_rise_s;
        // An acknowledge outside REQ, or one that matches nobody, is spurious.
        spur_set_s  = iack_rise_s && ((state_r != REQ) || (hit_s == 4'd0));
        // Only edge-mode sources are cleared by an acknowledge.
        ack_cand_s  = hit_s & mode_r;
        ack_clr_s   = ack_entry_s ? lowest_one(ack_cand_s) : 4'd0;
        wr_lo_s     = cs & wr[0];
        wr_hi_s     = cs & wr[1];
        w1c_s       = (wr_lo_s && (address == 3'd0)) ? din[3:0] : 4'd0;
        // Edge mode: a fresh edge beats any simultaneous clear. Level mode: follow s1.
        pending_next_s = (mode_r & (edge_s | (pending_r & ~(w1c_s | ack_clr_s))))
                       | (~mode_r & s1_r);
    end

    // FSM next state and the IPL value to register alongside it.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_level_s != 3'd0) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                // The CPU is already in its acknowledge cycle, so that takes priority.
                if (iack_rise_s) begin
                    state_next_s = ACK;
                end else if (req_level_s == 3'd0) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = REQ;
                end
            end
            ACK: begin
                if (!iack) begin
                    state_next_s = RECOVER;
                end else begin
                    state_next_s = ACK;
                end
            end
            RECOVER: state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        if (state_next_s == REQ) begin
            ipl_n_next_s = ~req_level_s;
        end else begin
            ipl_n_next_s = 3'b111;
        end
    end

    // Synchronisers, acknowledge edge detector, FSM state and registered IPL.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_r     <= 4'd0;
            s2_r     <= 4'd0;
            iack_d_r <= 1'b0;
            state_r  <= IDLE;
            ipl_n_r  <= 3'b111;
        end else begin
            s1_r     <= src;
            s2_r     <= s1_r;
            iack_d_r <= iack;
            state_r  <= state_next_s;
            ipl_n_r  <= ipl_n_next_s;
        end
    end

    // CPU-visible registers: pending, enable, mode, level and status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r    <= 4'd0;
            enable_r     <= 4'd0;
            mode_r       <= 4'hF;
            level_r      <= 12'h8D1;
            spurious_r   <= 1'b0;
            in_service_r <= 1'b0;
        end else begin
            pending_r <= pending_next_s;
            if (wr_lo_s && (address == 3'd1)) begin
                enable_r <= din[3:0];
            end else begin
                enable_r <= enable_r;
            end
            if (wr_lo_s && (address == 3'd2)) begin
                mode_r <= din[3:0];
            end else begin
                mode_r <= mode_r;
            end
            if (wr_lo_s && (address == 3'd3)) begin
                level_r[7:0] <= din[7:0];
            end else begin
                level_r[7:0] <= level_r[7:0];
            end
            if (wr_hi_s && (address == 3'd3)) begin
                level_r[11:8] <= din[11:8];
            end else begin
                level_r[11:8] <= level_r[11:8];
            end
            if (spur_set_s) begin
                spurious_r <= 1'b1;
            end else if (wr_hi_s && (address == 3'd4) && din[8]) begin
                spurious_r <= 1'b0;
            end else begin
                spurious_r <= spurious_r;
            end
            if (ack_entry_s) begin
                in_service_r <= 1'b1;
            end else if (state_r == RECOVER) begin
                in_service_r <= 1'b0;
            end else begin
                in_service_r <= in_service_r;
            end
        end
    end

    // Read mux; unused bits and unmapped addresses read as zero.
    always_comb begin
        dout = 16'h0000;
        case (address)
            3'd0:    dout = {12'h000, pending_r};
            3'd1:    dout = {12'h000, enable_r};
            3'd2:    dout = {12'h000, mode_r};
            3'd3:    dout = {4'h0, level_r};
            3'd4:    dout = {7'd0, spurious_r, 3'd0, in_service_r, 1'b0, ~ipl_n_r};
            default: dout = 16'h0000;
        endcase
    end

    assign ipl_n = ipl_n_r;

endmodule
